fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage that produces the `instruct` word the control decoder consumes, and takes back the decoder's `PCSel` redirect together with the ALU result. It holds the program counter, issues one request at a time to instruction memory, parks the returned word in an output register until downstream consumes it, then computes the next PC. It runs as a multicycle front end with at most one outstanding imem request.

## Interface
- `RESET_PC`, 32'h0000_0000, PC loaded on reset.
- `NOP_INSTR`, 32'h0000_0013, value driven on `instruct` when no valid instruction is held (`addi x0,x0,0`).

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `PCSel`  in  1  from decoder; 1 = take redirect for the instruction being consumed.
- `alu_out`  in  32  redirect target (branch/jal/jalr result).
- `stall`  in  1  1 = downstream cannot consume `instruct` this cycle.
- `imem_req`  out  1  request valid to instruction memory.
- `imem_addr`  out  32  word-aligned fetch address.
- `imem_ready`  in  1  memory accepts request this cycle.
- `imem_rvalid`  in  1  read data valid.
- `imem_rdata`  in  32  instruction word.
- `instruct`  out  32  held instruction to decoder.
- `instr_valid`  out  1  `instruct` is a real fetched instruction.
- `pc`  out  32  address of `instruct`.
- `pc_plus4`  out  32  `pc + 4` (mod 2^32), combinational from `pc`.
- `retired`  out  32  count of consumed instructions.

## Operation
- FSM states: REQ, WAIT, HOLD. Internal register `fetch_pc`.
- REQ:
  - `imem_req`=1, `imem_addr`=`fetch_pc`.
  - `imem_ready`=1 moves to WAIT; otherwise stays in REQ with address stable.
- WAIT:
  - `imem_req`=0.
  - On `imem_rvalid`=1: `instruct`<=`imem_rdata`, `pc`<=`fetch_pc`, `instr_valid`<=1, go to HOLD.
- HOLD:
  - `instr_valid`=1; `instruct` and `pc` stable.
  - Consumed when `stall`=0: `instr_valid`<=0, `instruct`<=`NOP_INSTR`, `retired`<=`retired`+1, go to REQ.
  - On that same edge, `fetch_pc` <= `PCSel` ? {`alu_out`[31:2],2'b00} : `fetch_pc`+4.
  - With `stall`=1 it holds indefinitely; `PCSel` is ignored.
- `PCSel` and `alu_out` are sampled only on the consume edge. They are don't-care in every other state.
- `imem_rvalid` in REQ or HOLD is a protocol violation: ignore it, change no state.
- Arithmetic:
  - `fetch_pc`+4 wraps 32'hFFFF_FFFC -> 32'h0000_0000.
  - `retired` wraps 32'hFFFF_FFFF -> 0.
  - Redirect target has bits [1:0] forced to 0.

## Timing
- Reset values: state=REQ, `fetch_pc`=`RESET_PC`, `pc`=`RESET_PC`, `instruct`=`NOP_INSTR`, `instr_valid`=0, `retired`=0.
- Reset outputs: `imem_req`=1 and `imem_addr`=`RESET_PC` right after reset (combinational from state).
- Reset asserted in any state takes effect immediately. An in-flight response arriving after reset deassert while in REQ is ignored.
- Zero-wait memory (`imem_ready`=1, `rvalid` one cycle after accept), with cycle 0 = first edge after reset release:
  - REQ accepted at edge 0.
  - rvalid sampled at edge 1.
  - `instr_valid`=1 from edge 1 to edge 2 (consumed at edge 2 if `stall`=0).
  - Next REQ from edge 2.
- Steady throughput: 3 cycles per instruction. Each `stall` cycle adds 1; each `imem_ready`=0 cycle adds 1.
- `pc_plus4` tracks `pc` with zero latency.

## Test plan
- Reset, memory returns 0x00300093 at address 0: `imem_addr`=0 → `instr_valid`=1, `instruct`=0x00300093, `pc`=0. The next request address is 4.
- `stall`=1 for 5 cycles in HOLD: `instruct`/`pc` unchanged, `imem_req`=0, `retired` unchanged. Release `stall`: `retired` increments by 1.
- Beq consumed with `PCSel`=1, `alu_out`=0x0000_0103: next `imem_addr`=0x0000_0100. Same consume with `PCSel`=0 at `pc`=0x10: next address 0x14.
- `imem_ready`=0 for 3 cycles in REQ: `imem_addr` held constant, no state advance. Spurious `imem_rvalid` in HOLD: `instruct` unchanged.
- `RESET_PC`=32'hFFFF_FFFC, consume without redirect: next `imem_addr`=0x0000_0000, `pc_plus4`=0 while `pc`=0xFFFF_FFFC.
- Assert `rst` while in WAIT: same cycle `instr_valid`=0, `instruct`=0x00000013. After release, `imem_req`=1, `imem_addr`=`RESET_PC`, `retired`=0.

Source files
------------

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : Multicycle instruction fetch with one outstanding imem request,
//            held output instruction and PC redirect on consume.
// Revision : 1.0
// ============================================================================
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PCSel,
    input  logic [31:0] alu_out,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruct,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] retired
);

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_fetch_pc;
    logic [31:0] r_pc;
    logic [31:0] r_instruct;
    logic        r_instr_valid;
    logic [31:0] r_retired;

    logic [31:0] w_redirect_pc;
    logic [31:0] w_seq_pc;

    // Redirect targets are forced word-aligned; sequential fetch wraps mod 2^32.
    assign w_redirect_pc = {alu_out[31:2], 2'b00};
    assign w_seq_pc      = r_fetch_pc + 32'd4;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= REQ;
            r_fetch_pc    <= RESET_PC;
            r_pc          <= RESET_PC;
            r_instruct    <= NOP_INSTR;
            r_instr_valid <= 1'b0;
            r_retired     <= 32'd0;
        end else begin
            case (r_state)
                REQ: begin
                    if (imem_ready) begin
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        r_instruct    <= imem_rdata;
                        r_pc          <= r_fetch_pc;
                        r_instr_valid <= 1'b1;
                        r_state       <= HOLD;
                    end
                end
                HOLD: begin
                    // PCSel/alu_out only matter on the edge the instruction is consumed.
                    if (!stall) begin
                        r_instr_valid <= 1'b0;
                        r_instruct    <= NOP_INSTR;
                        r_retired     <= r_retired + 32'd1;
                        r_fetch_pc    <= PCSel ? w_redirect_pc : w_seq_pc;
                        r_state       <= REQ;
                    end
                end
                default: begin
                    r_state <= REQ;
                end
            endcase
        end
    end

    assign imem_req    = (r_state == REQ);
    assign imem_addr   = r_fetch_pc;
    assign instruct    = r_instruct;
    assign instr_valid = r_instr_valid;
    assign pc          = r_pc;
    assign pc_plus4    = r_pc + 32'd4;
    assign retired     = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Purpose  : Scoreboard bench for fetch_unit with a task-driven imem model.
// Revision : 1.0
// ============================================================================
module tb_fetch_unit;

    localparam logic [31:0] C_NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        PCSel;
    logic [31:0] alu_out;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instruct;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] retired;

    int checks = 0;
    int errors = 0;

    logic [63:0] sb_q[$];
    logic [31:0] exp_fetch_pc;
    logic [31:0] exp_retired;

    fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .PCSel       (PCSel),
        .alu_out     (alu_out),
        .stall       (stall),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instruct    (instruct),
        .instr_valid (instr_valid),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .retired     (retired)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pop the expected fetch and compare against the held instruction.
    task automatic check_hold(input string name);
        logic [63:0] e;
        logic [31:0] e_p4;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL %s_sb_empty: instr_valid=%b instruct=%h, expected a queued fetch", name, instr_valid, instruct);
        end else begin
            e    = sb_q.pop_front();
            e_p4 = e[63:32] + 32'd4;
            if (instr_valid !== 1'b1 || instruct !== e[31:0] || pc !== e[63:32] || pc_plus4 !== e_p4) begin
                errors++;
                $display("FAIL %s_hold: valid=%b instr=%h pc=%h pc4=%h, expected valid=1 instr=%h pc=%h pc4=%h",
                         name, instr_valid, instruct, pc, pc_plus4, e[31:0], e[63:32], e_p4);
            end
        end
    endtask

    // Run one fetch from REQ to HOLD, with wait_cycles of imem_ready=0 first.
    task automatic issue(input string name, input logic [31:0] data, input int wait_cycles);
        for (int i = 0; i < wait_cycles; i++) begin
            imem_ready = 1'b0;
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== exp_fetch_pc || instr_valid !== 1'b0) begin
                errors++;
                $display("FAIL %s_req_stalled: req=%b addr=%h valid=%b, expected req=1 addr=%h valid=0",
                         name, imem_req, imem_addr, instr_valid, exp_fetch_pc);
            end
            step();
        end
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== exp_fetch_pc) begin
            errors++;
            $display("FAIL %s_req: req=%b addr=%h, expected req=1 addr=%h", name, imem_req, imem_addr, exp_fetch_pc);
        end
        sb_q.push_back({exp_fetch_pc, data});
        imem_ready = 1'b1;
        step();
        imem_ready = 1'b0;
        checks++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_wait: req=%b valid=%b, expected req=0 valid=0", name, imem_req, instr_valid);
        end
        imem_rdata  = data;
        imem_rvalid = 1'b1;
        step();
        imem_rvalid = 1'b0;
        imem_rdata  = 32'hDEAD_BEEF;
        check_hold(name);
    endtask

    task automatic consume(input string name, input logic sel, input logic [31:0] tgt);
        stall   = 1'b0;
        PCSel   = sel;
        alu_out = tgt;
        step();
        stall   = 1'b1;
        PCSel   = ~sel;
        alu_out = ~tgt;
        exp_retired  = exp_retired + 32'd1;
        exp_fetch_pc = sel ? {tgt[31:2], 2'b00} : exp_fetch_pc + 32'd4;
        checks++;
        if (instr_valid !== 1'b0 || instruct !== C_NOP || retired !== exp_retired ||
            imem_req !== 1'b1 || imem_addr !== exp_fetch_pc) begin
            errors++;
            $display("FAIL %s_consume: valid=%b instr=%h ret=%0d req=%b addr=%h, expected valid=0 instr=%h ret=%0d req=1 addr=%h",
                     name, instr_valid, instruct, retired, imem_req, imem_addr, C_NOP, exp_retired, exp_fetch_pc);
        end
    endtask

    task automatic test_reset();
        checks++;
        if (instr_valid !== 1'b0 || instruct !== C_NOP || pc !== 32'd0 || pc_plus4 !== 32'd4 ||
            retired !== 32'd0 || imem_req !== 1'b1 || imem_addr !== 32'd0) begin
            errors++;
            $display("FAIL reset: valid=%b instr=%h pc=%h pc4=%h ret=%0d req=%b addr=%h, expected 0 00000013 0 4 0 1 0",
                     instr_valid, instruct, pc, pc_plus4, retired, imem_req, imem_addr);
        end
    endtask

    task automatic test_basic();
        issue("basic", 32'h0030_0093, 0);
        consume("basic", 1'b0, 32'h0);
    endtask

    task automatic test_stall();
        logic [31:0] held_i;
        logic [31:0] held_pc;
        issue("stall", 32'h0041_0113, 0);
        held_i  = 32'h0041_0113;
        held_pc = exp_fetch_pc;
        for (int i = 0; i < 5; i++) begin
            // Spurious rvalid and PCSel while stalled in HOLD must be ignored.
            imem_rvalid = (i == 2);
            imem_rdata  = 32'hBAD0_0000 + 32'(i);
            PCSel       = 1'b1;
            alu_out     = 32'h0000_4000;
            step();
            imem_rvalid = 1'b0;
            checks++;
            if (instr_valid !== 1'b1 || instruct !== held_i || pc !== held_pc ||
                imem_req !== 1'b0 || retired !== exp_retired) begin
                errors++;
                $display("FAIL stall_hold: valid=%b instr=%h pc=%h req=%b ret=%0d, expected 1 %h %h 0 %0d",
                         instr_valid, instruct, pc, imem_req, retired, held_i, held_pc, exp_retired);
            end
        end
        consume("stall", 1'b0, 32'h0);
    endtask

    task automatic test_redirect();
        issue("beq", 32'h0000_0463, 0);
        consume("beq_taken", 1'b1, 32'h0000_0103);
        issue("at_100", 32'h0000_0013, 0);
        consume("to_10", 1'b1, 32'h0000_0010);
        issue("at_10", 32'h0000_0463, 0);
        consume("beq_not_taken", 1'b0, 32'hFFFF_0000);
    endtask

    task automatic test_ready_wait();
        issue("ready_wait", 32'h00A0_0293, 3);
        consume("ready_wait", 1'b0, 32'h0);
    endtask

    task automatic test_spurious_req();
        imem_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            imem_rvalid = 1'b1;
            imem_rdata  = 32'hCAFE_F00D;
            step();
            imem_rvalid = 1'b0;
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== exp_fetch_pc || instr_valid !== 1'b0 || instruct !== C_NOP) begin
                errors++;
                $display("FAIL spurious_req: req=%b addr=%h valid=%b instr=%h, expected 1 %h 0 %h",
                         imem_req, imem_addr, instr_valid, instruct, exp_fetch_pc, C_NOP);
            end
        end
        issue("after_spurious", 32'h0010_0073, 0);
        consume("after_spurious", 1'b0, 32'h0);
    endtask

    task automatic test_wrap();
        issue("jal_top", 32'h0000_006F, 0);
        consume("jal_top", 1'b1, 32'hFFFF_FFFF);
        issue("at_top", 32'h0000_0013, 0);
        consume("wrap", 1'b0, 32'h1234_5678);
        checks++;
        if (imem_addr !== 32'h0000_0000) begin
            errors++;
            $display("FAIL wrap_addr: addr=%h, expected 00000000", imem_addr);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) begin
            issue("b2b", $urandom, $urandom_range(0, 1));
            consume("b2b", 1'($urandom_range(0, 1)), $urandom);
        end
    endtask

    task automatic test_reset_in_wait();
        checks++;
        if (imem_req !== 1'b1) begin
            errors++;
            $display("FAIL rstwait_pre: req=%b, expected 1", imem_req);
        end
        imem_ready = 1'b1;
        step();
        imem_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        exp_fetch_pc = 32'h0;
        exp_retired  = 32'h0;
        checks++;
        if (instr_valid !== 1'b0 || instruct !== C_NOP || retired !== 32'd0 ||
            imem_req !== 1'b1 || imem_addr !== 32'd0 || pc !== 32'd0) begin
            errors++;
            $display("FAIL rst_in_wait: valid=%b instr=%h ret=%0d req=%b addr=%h pc=%h, expected 0 %h 0 1 0 0",
                     instr_valid, instruct, retired, imem_req, imem_addr, pc, C_NOP);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        // Stale response from the aborted request arrives while in REQ.
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h7777_7777;
        step();
        imem_rvalid = 1'b0;
        checks++;
        if (instr_valid !== 1'b0 || instruct !== C_NOP || imem_req !== 1'b1 ||
            imem_addr !== 32'd0 || retired !== 32'd0) begin
            errors++;
            $display("FAIL rst_release: valid=%b instr=%h req=%b addr=%h ret=%0d, expected 0 %h 1 0 0",
                     instr_valid, instruct, imem_req, imem_addr, retired, C_NOP);
        end
        issue("post_reset", 32'h0030_0093, 0);
        consume("post_reset", 1'b0, 32'h0);
    endtask

    initial begin
        rst          = 1'b1;
        PCSel        = 1'b0;
        alu_out      = 32'h0;
        stall        = 1'b1;
        imem_ready   = 1'b0;
        imem_rvalid  = 1'b0;
        imem_rdata   = 32'h0;
        exp_fetch_pc = 32'h0;
        exp_retired  = 32'h0;
        step();
        step();
        rst = 1'b0;

        test_reset();
        test_basic();
        test_stall();
        test_redirect();
        test_ready_wait();
        test_spurious_req();
        test_wrap();
        test_back_to_back();
        test_reset_in_wait();

        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: %0d entries, expected 0", sb_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
